// File: rtl/add_32_core.sv
// Digit-serial unsigned adder: captures two W-bit operands after reset release, adds SLICE bits
// per cycle with a registered ripple carry, and holds the zero-extended sum until the next reset.
module add_32_core #(
  parameter int unsigned W     = 32,
  parameter int unsigned SLICE = 8,
  parameter int unsigned RW    = 64
) (
  input  logic [W-1:0]  ina,
  input  logic [W-1:0]  inb,
  input  logic          clk,
  input  logic          rst,
  output logic [RW-1:0] result
);

  localparam int unsigned NSLICE = W / SLICE;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NSLICE - 1);

  if ((W % SLICE) != 0) begin : g_bad_slice
    $error("add_32_core: SLICE must divide W");
  end
  if (RW < W + 1) begin : g_bad_rw
    $error("add_32_core: RW must be at least W+1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_WB,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [RW-1:0]   result_q, result_d;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE:0]   slice_sum;

  // Select the operand slice addressed by the slice counter.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < int'(NSLICE); i++) begin
      if (idx_q == CW'(i)) begin
        a_sl = a_q[i*SLICE +: SLICE];
        b_sl = b_q[i*SLICE +: SLICE];
      end
    end
    slice_sum = (SLICE+1)'(a_sl) + (SLICE+1)'(b_sl) + (SLICE+1)'(carry_q);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        a_d     = ina;
        b_d     = inb;
        carry_d = 1'b0;
        idx_d   = '0;
        state_d = S_ADD;
      end
      S_ADD: begin
        for (int i = 0; i < int'(NSLICE); i++) begin
          if (idx_q == CW'(i)) begin
            sum_d[i*SLICE +: SLICE] = slice_sum[SLICE-1:0];
          end
        end
        carry_d = slice_sum[SLICE];
        idx_d   = CW'(idx_q + 1'b1);
        if (idx_q == LAST_IDX) begin
          state_d = S_WB;
        end
      end
      // Result register is only written once the full sum and final carry are settled.
      S_WB: begin
        result_d = RW'({carry_q, sum_q});
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_add_32_core.sv
// Scoreboarded bench for add_32_core: a driver issues reset-started additions and queues the
// expected sums; a monitor tracks edges since reset release and checks result against them.
module tb_add_32_core;

  logic        clk;
  logic        rst;
  logic [31:0] ina;
  logic [31:0] inb;
  logic [63:0] result;

  int n_tests;
  int n_fail;

  logic [63:0] exp_q[$];

  add_32_core dut (
    .ina   (ina),
    .inb   (inb),
    .clk   (clk),
    .rst   (rst),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_sum(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) + 64'(b);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, required 0x%016h at %0t", name, act, req, $time);
    end
  endtask

  // Reset with operands a/b, release, then run n_edges edges. Inputs are scrambled after
  // edge change_at and reset is re-asserted after edge abort_at (0 disables either).
  task automatic txn(input logic [31:0] a, input logic [31:0] b, input int n_edges,
                     input int change_at, input int abort_at);
    @(posedge clk); #1;
    rst = 1'b1;
    ina = a;
    inb = b;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(ref_sum(a, b));
    for (int k = 1; k <= n_edges; k++) begin
      @(posedge clk); #1;
      if (k == change_at) begin
        ina = $urandom;
        inb = $urandom;
      end
      if (k == abort_at) begin
        rst = 1'b1;
        return;
      end
    end
  endtask

  // Monitor: count edges sampled with rst low; result must be 0 for edges 1..5, the queued sum
  // at edge 6 and unchanged afterwards. A reset before edge 6 retires the pending entry unchecked.
  initial begin : monitor
    int          cnt;
    logic        r;
    logic [63:0] cur;
    cnt = 0;
    cur = '0;
    forever begin
      @(posedge clk);
      r = rst;
      @(negedge clk);
      if (r === 1'b1) begin
        if (cnt >= 1 && cnt <= 5 && exp_q.size() > 0) void'(exp_q.pop_front());
        cnt = 0;
        check("reset_zero", result, 64'h0);
      end else if (r === 1'b0) begin
        cnt++;
        if (cnt < 6) begin
          check("busy_zero", result, 64'h0);
        end else if (cnt == 6) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: result 0x%016h with no expected entry", result);
          end else begin
            cur = exp_q.pop_front();
            check("sum", result, cur);
          end
        end else begin
          check("hold", result, cur);
        end
      end
    end
  end

  initial begin : driver
    logic [31:0] a;
    logic [31:0] b;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    ina = '0;
    inb = '0;
    repeat (2) @(posedge clk);

    txn(32'h0000_0001, 32'h0000_0001, 9, 0, 0);
    txn(32'h03fd_0010, 32'h01da_0100, 12, 0, 0);
    txn(32'hffff_ffff, 32'h0000_0001, 8, 0, 0);
    txn(32'hffff_ffff, 32'hffff_ffff, 8, 0, 0);
    txn(32'h0000_0000, 32'h0000_0000, 7, 0, 0);
    txn(32'h1234_5678, 32'h8765_4321, 9, 2, 0);
    txn(32'h00ff_00ff, 32'h0001_0001, 9, 0, 3);
    txn(32'h7fff_ffff, 32'h0000_0001, 8, 0, 0);
    txn(32'h80ff_ff00, 32'h8000_0100, 8, 0, 0);

    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      b = $urandom;
      if (t % 8 == 3) txn(a, b, 6 + int'($urandom_range(0, 5)), 0, 1 + int'($urandom_range(0, 4)));
      else txn(a, b, 6 + int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), 0);
    end

    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
